fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the program counter, issues word requests to instruction memory, and buffers returned instructions in a small FIFO. Presents `pc`/instruction pairs to the IF/ID boundary with a valid/ready handshake. Drops stale in-flight responses when the branch/jump resolution stage redirects the PC.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 40 ++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and FIFO entry type for the fetch stage
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead FIFO with synchronous flush; the head is read directly from the register array
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_full;
  logic        w_pop;
  assign count   = r_wr - r_rd;
  assign w_full  = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
  assign w_pop   = pop && (r_wr != r_rd);
  assign rd_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr[AW-1:0]] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (reset && !flush && push && !w_pop) assert (!w_full);
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited imem requests, stale-response dropping and a registered
// instruction FIFO feeding the IF/ID handshake
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] iaddr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  input  logic        ifid_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0]  r_pc_q;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_fifo_cnt;
  logic [CW-1:0] w_pcq_cnt;
  logic [CW:0]   w_credit;
  logic [31:0]   w_pcq_head;
  logic          w_pop;
  logic          w_acc;
  logic          w_keep;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push;
  assign w_pop          = ifid_valid && ifid_ready;
  assign w_credit       = {1'b0, r_out_cnt} + {1'b0, w_fifo_cnt} - (CW+1)'(w_pop);
  assign imem_req_valid = reset && (w_credit < (CW+1)'(DEPTH));
  assign iaddr          = r_pc_q;
  assign w_acc          = imem_req_valid && imem_req_ready;
  assign w_keep         = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_out_nxt      = r_out_cnt + CW'(w_acc) - CW'(imem_rsp_valid);
  assign w_push         = '{pc: w_pcq_head, instr: idata};
  assign ifid_valid     = w_fifo_cnt != '0;
  assign ifid_instr     = ifid_valid ? w_head.instr : NOP_INSTR;
  assign ifid_pc        = ifid_valid ? w_head.pc : r_pc_q;
  // out_cnt counts every outstanding request, dropped or not, so it alone bounds imem occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc_q     <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_out_cnt  <= w_out_nxt;
      r_pc_q     <= redirect_valid ? (redirect_pc & ~32'd3) : w_acc ? r_pc_q + 32'd4 : r_pc_q;
      r_drop_cnt <= redirect_valid ? w_out_nxt
                  : (imem_rsp_valid && r_drop_cnt != '0) ? r_drop_cnt - CW'(1) : r_drop_cnt;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_pcq (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (w_acc),
    .push_data (r_pc_q),
    .pop       (w_keep),
    .rd_data   (w_pcq_head),
    .count     (w_pcq_cnt)
  );
  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (w_keep),
    .push_data (w_push),
    .pop       (w_pop),
    .rd_data   (w_head),
    .count     (w_fifo_cnt)
  );
  always_ff @(posedge clk) begin
    if (reset) assert (w_pcq_cnt <= r_out_cnt);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized imem/decode environment with an in-order instruction-stream model
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] iaddr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] idata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifid_valid;
  logic        ifid_ready = 1'b0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .iaddr          (iaddr),
    .imem_rsp_valid (imem_rsp_valid),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_ready     (ifid_ready),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    int          due;
  } req_t;
  req_t        q[$];
  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          last_due = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          p_req = 100;
  int          p_rdy = 100;
  logic        rst_drv = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;
  logic        hold = 1'b0;
  logic        flushed = 1'b0;
  logic        obs_valid, obs_req_valid, obs_pop, obs_rsp;
  logic [31:0] obs_pc, obs_instr, obs_iaddr;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
  endfunction
  // One clock: drive at negedge, sample 1ns later, then score against the stream model
  task automatic cycle();
    int d;
    @(negedge clk);
    cyc++;
    reset          = rst_drv;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    imem_req_ready = int'($urandom_range(0, 99)) < p_req;
    ifid_ready     = int'($urandom_range(0, 99)) < p_rdy;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      idata          = mem_word(q[0].a);
      void'(q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      idata          = $urandom;
    end
    #1;
    obs_valid     = ifid_valid;
    obs_pc        = ifid_pc;
    obs_instr     = ifid_instr;
    obs_req_valid = imem_req_valid;
    obs_iaddr     = iaddr;
    obs_pop       = ifid_valid && ifid_ready;
    obs_rsp       = imem_rsp_valid;
    if (!rst_drv) begin
      vectors++;
      if (imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL req_in_reset: got %b want 0", imem_req_valid);
      end
      q.delete();
      exp_pc  = RESET_PC;
      exp_req = RESET_PC;
      hold    = 1'b0;
      flushed = 1'b1;
    end else begin
      if (flushed) begin
        vectors++;
        if (ifid_valid !== 1'b0) begin
          errors++; $display("FAIL flush_empty: got valid=%b pc=%h want valid=0", ifid_valid, ifid_pc);
        end
      end
      if (hold) begin
        vectors++;
        if (ifid_valid !== 1'b1 || ifid_pc !== hold_pc || ifid_instr !== hold_instr) begin
          errors++; $display("FAIL hold_stable: got %b %h %h want 1 %h %h", ifid_valid, ifid_pc, ifid_instr, hold_pc, hold_instr);
        end
      end
      vectors++;
      if (ifid_valid === 1'b1) begin
        if (ifid_instr !== mem_word(ifid_pc)) begin
          errors++; $display("FAIL instr_data: pc %h got %h want %h", ifid_pc, ifid_instr, mem_word(ifid_pc));
        end
      end else if (ifid_instr !== NOP_INSTR) begin
        errors++; $display("FAIL idle_nop: got %h want %h", ifid_instr, NOP_INSTR);
      end
      if (ifid_valid && ifid_ready) begin
        vectors++;
        pops++;
        if (ifid_pc !== exp_pc) begin
          errors++; $display("FAIL stream_order: got pc %h want %h", ifid_pc, exp_pc);
        end
        exp_pc += 32'd4;
      end
      if (imem_req_valid) begin
        vectors++;
        if (iaddr !== exp_req) begin
          errors++; $display("FAIL iaddr: got %h want %h", iaddr, exp_req);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        d = cyc + int'($urandom_range(lat_lo, lat_hi));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        q.push_back('{a: iaddr, due: d});
        exp_req += 32'd4;
      end
      vectors++;
      if (q.size() > DEPTH) begin
        errors++; $display("FAIL outstanding: got %0d want <= %0d", q.size(), DEPTH);
      end
      if (redir) begin
        exp_pc  = redir_pc & ~32'd3;
        exp_req = redir_pc & ~32'd3;
      end
      hold       = ifid_valid && !ifid_ready && !redir;
      hold_pc    = ifid_pc;
      hold_instr = ifid_instr;
      flushed    = redir;
    end
    redir = 1'b0;
  endtask
  task automatic wait_first(input string name, input logic [31:0] want, input int min_k);
    int fk = 0;
    for (int k = 1; k <= 20 && fk == 0; k++) begin
      cycle();
      if (obs_valid) fk = k;
    end
    vectors++;
    if (fk == 0) begin
      errors++; $display("FAIL %s: got no instruction want pc %h within 20 cycles", name, want);
    end else if (obs_pc !== want || fk < min_k) begin
      errors++; $display("FAIL %s: got pc %h after %0d cycles want %h after >= %0d", name, obs_pc, fk, want, min_k);
    end
  endtask
  task automatic test_reset();
    rst_drv = 1'b0;
    repeat (3) cycle();
    vectors++;
    if (obs_valid !== 1'b0 || obs_instr !== NOP_INSTR) begin
      errors++; $display("FAIL reset_ifid: got %b %h want 0 %h", obs_valid, obs_instr, NOP_INSTR);
    end
    vectors++;
    if (obs_pc !== RESET_PC) begin
      errors++; $display("FAIL reset_ifid_pc: got %h want %h", obs_pc, RESET_PC);
    end
    vectors++;
    if (obs_iaddr !== RESET_PC) begin
      errors++; $display("FAIL reset_iaddr: got %h want %h", obs_iaddr, RESET_PC);
    end
  endtask
  task automatic test_startup();
    rst_drv = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i <= 3) begin
        vectors++;
        if (obs_req_valid !== 1'b1 || obs_iaddr !== 32'((i - 1) * 4)) begin
          errors++; $display("FAIL startup_req%0d: got %b %h want 1 %h", i, obs_req_valid, obs_iaddr, 32'((i - 1) * 4));
        end
      end
      vectors++;
      if (obs_valid !== logic'(i >= 3)) begin
        errors++; $display("FAIL startup_valid%0d: got %b want %b", i, obs_valid, logic'(i >= 3));
      end
      if (i >= 3) begin
        vectors++;
        if (obs_pc !== 32'((i - 3) * 4)) begin
          errors++; $display("FAIL startup_pc%0d: got %h want %h", i, obs_pc, 32'((i - 3) * 4));
        end
      end
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] hp = '0;
    p_rdy = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 1) hp = obs_pc;
      vectors++;
      if (obs_valid !== 1'b1 || obs_pc !== hp) begin
        errors++; $display("FAIL stall%0d: got %b %h want 1 %h", i, obs_valid, obs_pc, hp);
      end
      if (i >= 2) begin
        vectors++;
        if (obs_req_valid !== 1'b0) begin
          errors++; $display("FAIL stall_req%0d: got %b want 0", i, obs_req_valid);
        end
      end
    end
    p_rdy = 100;
    cycle();
    vectors++;
    if (obs_valid !== 1'b1 || obs_pc !== hp) begin
      errors++; $display("FAIL stall_release: got %b %h want 1 %h", obs_valid, obs_pc, hp);
    end
    repeat (8) cycle();
  endtask
  task automatic test_redirect_drop();
    logic found = 1'b0;
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      found = q.size() == 2;
    end
    vectors++;
    if (!found) begin
      errors++; $display("FAIL drop_setup: got %0d outstanding want 2", q.size());
    end
    redir = 1'b1; redir_pc = 32'h100;
    cycle();
    cycle();
    vectors++;
    if (obs_iaddr !== 32'h100) begin
      errors++; $display("FAIL drop_iaddr: got %h want %h", obs_iaddr, 32'h100);
    end
    wait_first("drop_first", 32'h100, 4);
    repeat (6) cycle();
  endtask
  task automatic test_redirect_misaligned();
    lat_lo = 1; lat_hi = 1;
    repeat (4) cycle();
    redir = 1'b1; redir_pc = 32'h203;
    cycle();
    cycle();
    vectors++;
    if (obs_iaddr !== 32'h200) begin
      errors++; $display("FAIL misalign_iaddr: got %h want %h", obs_iaddr, 32'h200);
    end
    wait_first("misalign_first", 32'h200, 2);
    repeat (4) cycle();
  endtask
  task automatic test_redirect_collision();
    logic [31:0] e;
    repeat (6) cycle();
    e = exp_pc;
    redir = 1'b1; redir_pc = 32'h400;
    cycle();
    vectors++;
    if (obs_pop !== 1'b1 || obs_rsp !== 1'b1 || obs_pc !== e) begin
      errors++; $display("FAIL collide_pop: got pop=%b rsp=%b pc=%h want 1 1 %h", obs_pop, obs_rsp, obs_pc, e);
    end
    wait_first("collide_first", 32'h400, 3);
    repeat (6) cycle();
  endtask
  task automatic test_reset_midstream();
    p_rdy = 0;
    repeat (6) cycle();
    vectors++;
    if (obs_valid !== 1'b1 || obs_req_valid !== 1'b0) begin
      errors++; $display("FAIL full_before_reset: got valid=%b req=%b want 1 0", obs_valid, obs_req_valid);
    end
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1; p_rdy = 100;
    cycle();
    vectors++;
    if (obs_valid !== 1'b0 || obs_iaddr !== RESET_PC || obs_req_valid !== 1'b1) begin
      errors++; $display("FAIL after_reset: got %b %h %b want 0 %h 1", obs_valid, obs_iaddr, obs_req_valid, RESET_PC);
    end
    wait_first("reset_resume", RESET_PC, 2);
    repeat (4) cycle();
  endtask
  task automatic test_wrap();
    logic [31:0] got [2];
    int n = 0;
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    cycle();
    for (int i = 0; i < 20 && n < 2; i++) begin
      cycle();
      if (obs_pop) begin
        got[n] = obs_pc;
        n++;
      end
    end
    vectors++;
    if (n != 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
      errors++; $display("FAIL wrap: got %0d pops %h %h want 2 fffffffc 00000000", n, got[0], got[1]);
    end
    repeat (4) cycle();
  endtask
  task automatic test_random();
    int p0 = pops;
    lat_lo = 1; lat_hi = 4; p_req = 75; p_rdy = 65;
    for (int i = 0; i < 3000; i++) begin
      redir    = int'($urandom_range(0, 99)) < 3;
      redir_pc = $urandom;
      rst_drv  = int'($urandom_range(0, 999)) >= 3;
      cycle();
    end
    rst_drv = 1'b1; p_req = 100; p_rdy = 100; lat_lo = 1; lat_hi = 1;
    repeat (10) cycle();
    vectors++;
    if (pops - p0 < 200) begin
      errors++; $display("FAIL random_progress: got %0d deliveries want >= 200", pops - p0);
    end
  endtask
  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect_drop();
    test_redirect_misaligned();
    test_redirect_collision();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
